// File: rtl/spi_master_xfer_ctrl.sv
// SPI master transfer controller: sequences CS, SDO launch and SDI capture from clock-generator pulses.
// Optional feature macro SPI_XFER_CTRL_LSB_FIRST_EN adds a per-command lsb_first bit order select.
module spi_master_xfer_ctrl #(
   parameter int CS_GAP = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   output logic        ready,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] tx_data,
   output logic [31:0] rx_data,
   output logic        done,
   output logic        busy,
   output logic        clkgen_en,
   input  logic        spi_fall,
   input  logic        spi_rise,
   output logic        spi_csn,
   output logic        spi_sdo,
   input  logic        spi_sdi
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
   ,
   input  logic        lsb_first
`endif
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   localparam logic [3:0] GAP_LOAD = 4'(CS_GAP - 1);

   state_t      state;
   logic [31:0] tx_sr;
   logic [31:0] rx_sr;
   logic [4:0]  bit_cnt;
   logic [3:0]  gap_cnt;
   logic        tx_bit;
   logic [31:0] tx_next;
   logic [31:0] rx_next;
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
   logic        lsb_q;
   logic [4:0]  len_q;
`endif

   assign rx_data = rx_sr;

   always_comb begin
      tx_bit  = tx_sr[31];
      tx_next = {tx_sr[30:0], 1'b0};
      rx_next = {rx_sr[30:0], spi_sdi};
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
      // LSB-first rx enters at bit N-1 and walks down, so bits above N-1 stay zero
      if (lsb_q) begin
         tx_bit  = tx_sr[0];
         tx_next = {1'b0, tx_sr[31:1]};
         rx_next = (rx_sr >> 1) | ({31'd0, spi_sdi} << len_q);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         spi_csn   <= 1'b1;
         clkgen_en <= 1'b0;
         spi_sdo   <= 1'b0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
         lsb_q     <= 1'b0;
         len_q     <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state   <= SETUP;
               ready   <= 1'b0;
               busy    <= 1'b1;
               spi_csn <= 1'b0;
               tx_sr   <= tx_data;
               rx_sr   <= '0;
               bit_cnt <= cmd_len;
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
               lsb_q   <= lsb_first;
               len_q   <= cmd_len;
`endif
            end
            SETUP: begin
               state     <= SHIFT;
               clkgen_en <= 1'b1;
            end
            SHIFT: begin
               if (spi_fall) begin
                  spi_sdo <= tx_bit;
                  tx_sr   <= tx_next;
               end
               if (spi_rise) begin
                  rx_sr   <= rx_next;
                  bit_cnt <= bit_cnt - 5'd1;
                  if (bit_cnt == 5'd0) begin
                     state     <= HOLD;
                     clkgen_en <= 1'b0;
                  end
               end
            end
            HOLD: begin
               state   <= GAP;
               spi_csn <= 1'b1;
               done    <= 1'b1;
               gap_cnt <= GAP_LOAD;
            end
            GAP: begin
               if (gap_cnt == 4'd0) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
